mult_share_ctrl: RTL and testbench

//  Round-robin controller that time-shares one sequential shift-add multiplier among N_REQ requesters.
//  - Grants one requester, latches its operands and pulses the multiplier's start.
//  - Waits for ready, then returns the registered product with a one-cycle done pulse to the granted requester.
//  - Sits between requester logic and a single multiplication_top instance.

---
 rtl/mult_share_ctrl_pkg.sv | 21 ++
 rtl/mult_share_ctrl_if.sv | 30 +++
 rtl/mult_share_ctrl_rr_pick.sv | 37 +++
 rtl/mult_share_ctrl.sv | 142 ++++++++++++++
 tb/tb_mult_share_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_share_ctrl_pkg.sv
// Shared types and elaboration helpers for the round-robin multiplier-sharing controller.
package mult_share_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_SETTLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  // The multiplier product carries one guard bit above the natural 2*WIDTH width.
  function automatic bit res_w_ok(input int width, input int res_w);
    return res_w == 2 * width + 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_if.sv
// Requester-side and multiplier-side signals of the shared-multiplier controller.
interface mult_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int RES_W = 9
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] a_flat;
  logic [N_REQ*WIDTH-1:0] b_flat;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       done;
  logic [RES_W-1:0]       result_out;
  logic                   busy;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic                   mul_start;
  logic                   mul_ready;
  logic [RES_W-1:0]       mul_result;
  logic                   err;

  modport slave (
    input  req, a_flat, b_flat, mul_ready, mul_result,
    output gnt, done, result_out, busy, mul_a, mul_b, mul_start, err
  );

  modport master (
    output req, a_flat, b_flat, mul_ready, mul_result,
    input  gnt, done, result_out, busy, mul_a, mul_b, mul_start, err
  );
endinterface

// File: rtl/mult_share_ctrl_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr_i, wrapping.
module mult_share_ctrl_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  function automatic logic [IDX_W-1:0] slot(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    // Scan farthest-first so the nearest requester at or after the pointer wins.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      for (int j = 0; j < N_REQ; j++) begin
        if (req_i[j] && (slot(rr_ptr_i, k) == IDX_W'(j))) begin
          pick_o    = '0;
          pick_o[j] = 1'b1;
          idx_o     = IDX_W'(j);
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin controller time-sharing one sequential multiplier among N_REQ requesters.
// Optional watchdog on the multiplier wait is enabled by defining MSC_TIMEOUT_EN.
module mult_share_ctrl
  import mult_share_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int RES_W   = 9,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                reset,
  mult_share_ctrl_if.slave    bus
);

  localparam int IDX_W = idx_w(N_REQ);

  if (!res_w_ok(WIDTH, RES_W)) begin : g_bad_res_w
    $error("mult_share_ctrl: RES_W must equal 2*WIDTH+1");
  end
  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("mult_share_ctrl: N_REQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e           state_q;
  logic [N_REQ-1:0] gnt_q, done_q;
  logic [IDX_W-1:0] gidx_q, rr_ptr_q;
  logic [RES_W-1:0] res_q;
  logic             busy_q, mul_start_q;
  logic [WIDTH-1:0] mul_a_q, mul_b_q;

  logic [N_REQ-1:0] pick_d;
  logic [IDX_W-1:0] pick_idx_d;
  logic             any_d;
  logic [WIDTH-1:0] op_a_d, op_b_d;

  mult_share_ctrl_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (bus.req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick_d),
    .idx_o    (pick_idx_d),
    .any_o    (any_d)
  );

  always_comb begin
    op_a_d = '0;
    op_b_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_d[i]) begin
        op_a_d = bus.a_flat[i*WIDTH +: WIDTH];
        op_b_d = bus.b_flat[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef MSC_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT) + 1;
  logic             err_q;
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      done_q      <= '0;
      res_q       <= '0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_start_q <= 1'b0;
`ifdef MSC_TIMEOUT_EN
      err_q       <= 1'b0;
      tmo_q       <= '0;
`endif
    end else begin
      mul_start_q <= 1'b0;
      done_q      <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_d) begin
            gnt_q       <= pick_d;
            gidx_q      <= pick_idx_d;
            mul_a_q     <= op_a_d;
            mul_b_q     <= op_b_d;
            mul_start_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_SETTLE;
        // The multiplier still shows its previous ready here, so it is not sampled.
        S_SETTLE: begin
`ifdef MSC_TIMEOUT_EN
          tmo_q <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.mul_ready) begin
            res_q   <= bus.mul_result;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end
`ifdef MSC_TIMEOUT_EN
          else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            res_q   <= '0;
            done_q  <= gnt_q;
            state_q <= S_DONE;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
`endif
        end
        S_DONE: begin
          rr_ptr_q <= (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
          gnt_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.result_out = res_q;
  assign bus.busy       = busy_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.mul_start  = mul_start_q;
`ifdef MSC_TIMEOUT_EN
  assign bus.err        = err_q;
`else
  assign bus.err        = 1'b0;
`endif

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl with a behavioural shift-add multiplier model.
module tb_mult_share_ctrl;
  localparam int N = 4, W = 4, R = 9, TMO = 8, LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stall = 1'b0;
  always #5 clk = ~clk;

  mult_share_ctrl_if #(.N_REQ(N), .WIDTH(W), .RES_W(R)) bus ();

  mult_share_ctrl #(.N_REQ(N), .WIDTH(W), .RES_W(R), .TIMEOUT(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Multiplier model: ready drops the edge after start, product appears LAT edges later.
  int           m_cnt;
  logic [R-1:0] m_prod;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.mul_ready  <= 1'b1;
      bus.mul_result <= '0;
      m_cnt          <= 0;
      m_prod         <= '0;
    end else if (bus.mul_start) begin
      m_cnt          <= LAT;
      bus.mul_ready  <= 1'b0;
      bus.mul_result <= 9'h1AB;
      m_prod         <= R'(bus.mul_a) * R'(bus.mul_b);
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1 && !stall) begin
        bus.mul_ready  <= 1'b1;
        bus.mul_result <= m_prod;
      end
    end
  end

  typedef struct packed {
    logic [N-1:0] done;
    logic [R-1:0] res;
  } exp_t;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] a;
    logic [N*W-1:0] b;
    int             idx;
    logic [R-1:0]   res;
  } vec_t;

  exp_t sb[$];
  vec_t vt[9];
  int n_cmp = 0, n_err = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    chk("gnt_onehot", 32'($onehot0(bus.gnt)), 1);
    if (bus.done != '0) begin
      n_done++;
      if (sb.size() == 0) chk("unexpected_done", 32'(bus.done), 0);
      else begin
        e = sb.pop_front();
        chk("done", 32'(bus.done), 32'(e.done));
        chk("result", 32'(bus.result_out), 32'(e.res));
      end
    end
  endtask

  task automatic wait_dones(input int target, input int budget);
    int t = 0;
    while (n_done < target && t < budget) begin
      step();
      t++;
    end
    chk("done_within_budget", 32'(n_done >= target), 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_result"}, 32'(bus.result_out), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_mul_a"}, 32'(bus.mul_a), 0);
    chk({tag, "_mul_b"}, 32'(bus.mul_b), 0);
    chk({tag, "_mul_start"}, 32'(bus.mul_start), 0);
    chk({tag, "_err"}, 32'(bus.err), 0);
  endtask

  task automatic run_txn(input logic [N-1:0] req, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                         input int idx, input logic [R-1:0] res);
    int tgt;
    exp_t e;
    bus.req = req;
    bus.a_flat = a;
    bus.b_flat = b;
    e.done = N'(1 << idx);
    e.res = res;
    sb.push_back(e);
    tgt = n_done + 1;
    step();
    chk("grant", 32'(bus.gnt), 32'(1 << idx));
    chk("mul_start", 32'(bus.mul_start), 1);
    chk("busy", 32'(bus.busy), 1);
    chk("mul_a", 32'(bus.mul_a), 32'(a[idx*W +: W]));
    chk("mul_b", 32'(bus.mul_b), 32'(b[idx*W +: W]));
    wait_dones(tgt, 40);
    bus.req = '0;
    step();
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_gnt", 32'(bus.gnt), 0);
    chk("result_held", 32'(bus.result_out), 32'(res));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

  initial begin
    int tgt;
    exp_t e;
    vt[0] = '{4'b0001, 16'h432B, 16'h5679, 0, 9'd99};
    vt[1] = '{4'b0100, 16'h1F23, 16'h2F45, 2, 9'd225};
    vt[2] = '{4'b0011, 16'h6540, 16'h321D, 0, 9'd0};
    vt[3] = '{4'b1010, 16'h2371, 16'h9486, 1, 9'd56};
    vt[4] = '{4'b1001, 16'h9111, 16'hC222, 3, 9'd108};
    vt[5] = '{4'b1111, 16'h5551, 16'h7771, 0, 9'd1};
    vt[6] = '{4'b0001, 16'hEEEF, 16'hEEE0, 0, 9'd0};
    vt[7] = '{4'b0100, 16'h0D00, 16'h0B00, 2, 9'd143};
    vt[8] = '{4'b1000, 16'hF000, 16'hE000, 3, 9'd210};

    bus.req = '0;
    bus.a_flat = '0;
    bus.b_flat = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;
    step();

    for (int i = 0; i < 9; i++) run_txn(vt[i].req, vt[i].a, vt[i].b, vt[i].idx, vt[i].res);

    // All four requesting from a fresh pointer: strict rotation.
    reset = 1'b0;
    step();
    reset = 1'b1;
    bus.req = 4'b1111;
    bus.a_flat = 16'h4321;
    bus.b_flat = 16'h3333;
    for (int i = 0; i < N; i++) begin
      e.done = N'(1 << i);
      e.res = R'(3 * (i + 1));
      sb.push_back(e);
    end
    tgt = n_done + N;
    for (int t = 0; t < 200 && n_done < tgt; t++) begin
      step();
      bus.req = bus.req & ~bus.done;
    end
    chk("rotate_all_done", 32'(n_done), 32'(tgt));
    bus.req = '0;
    step();

    // Pointer wraps from 3 to requester 0.
    run_txn(4'b0100, 16'h7532, 16'h8641, 2, 9'd30);
    run_txn(4'b0001, 16'h321F, 16'h321F, 0, 9'd225);

    // Requester 1 keeps requesting after its done; requester 0 is served in between.
    bus.req = 4'b0011;
    bus.a_flat = 16'h0065;
    bus.b_flat = 16'h0073;
    e.done = 4'b0010; e.res = 9'd42; sb.push_back(e);
    e.done = 4'b0001; e.res = 9'd15; sb.push_back(e);
    e.done = 4'b0010; e.res = 9'd42; sb.push_back(e);
    wait_dones(n_done + 3, 120);
    bus.req = '0;
    repeat (2) step();

    // Operands change and req drops after grant; latched operands still used.
    bus.req = 4'b0001;
    bus.a_flat = 16'h000B;
    bus.b_flat = 16'h0009;
    e.done = 4'b0001; e.res = 9'd99; sb.push_back(e);
    tgt = n_done + 1;
    step();
    chk("drop_grant", 32'(bus.gnt), 1);
    bus.a_flat = 16'h0002;
    repeat (3) step();
    bus.req = '0;
    wait_dones(tgt, 40);
    repeat (6) step();
    chk("drop_single_done", 32'(n_done), 32'(tgt));

    // Reset during WAIT aborts without a done; request is re-served after release.
    bus.req = 4'b0010;
    bus.a_flat = 16'h00D0;
    bus.b_flat = 16'h0070;
    step();
    chk("pre_reset_grant", 32'(bus.gnt), 32'h2);
    repeat (3) step();
    reset = 1'b0;
    #1;
    chk_zero("abort");
    step();
    chk_zero("abort_hold");
    e.done = 4'b0010; e.res = 9'd91; sb.push_back(e);
    tgt = n_done + 1;
    reset = 1'b1;
    step();
    chk("regrant", 32'(bus.gnt), 32'h2);
    wait_dones(tgt, 40);
    bus.req = '0;
    step();

    // Multiplier never becomes ready.
    stall = 1'b1;
    bus.req = 4'b0100;
    bus.a_flat = 16'h0300;
    bus.b_flat = 16'h0300;
`ifdef MSC_TIMEOUT_EN
    e.done = 4'b0100; e.res = 9'd0; sb.push_back(e);
    tgt = n_done + 1;
    step();
    chk("stall_grant", 32'(bus.gnt), 32'h4);
    wait_dones(tgt, 40);
    chk("timeout_err", 32'(bus.err), 1);
    bus.req = '0;
    step();
    chk("timeout_result_zero", 32'(bus.result_out), 0);
    stall = 1'b0;
    run_txn(4'b1000, 16'h2000, 16'h3000, 3, 9'd6);
    chk("err_sticky", 32'(bus.err), 1);
`else
    tgt = n_done;
    step();
    chk("stall_grant", 32'(bus.gnt), 32'h4);
    repeat (30) step();
    chk("stall_busy", 32'(bus.busy), 1);
    chk("stall_gnt", 32'(bus.gnt), 32'h4);
    chk("stall_err", 32'(bus.err), 0);
    chk("stall_no_done", 32'(n_done), 32'(tgt));
    reset = 1'b0;
    bus.req = '0;
    stall = 1'b0;
    step();
    reset = 1'b1;
    step();
`endif
    chk("scoreboard_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
